pwm_decoder: RTL and testbench
==============================

# pwm_decoder

Receive-side counterpart of the button-controlled PWM generator. Samples an asynchronous PWM input, measures the high time of every PWM frame, and reports the duty as an integer count of clock cycles, 0..PERIOD. Frames whose period does not match PERIOD are flagged as errors. Used on the loop-back and monitor path to confirm the generated duty code.

## Interface
- `PERIOD`, default 10: expected frame length in clock cycles. Matches the generator's 10-cycle frame. Legal range 2..2^CNT_W−1.
- `CNT_W`, default 4: width of the counters and of `o_duty`.
- `i_clk`, input, 1: single clock (100 kHz in the reference system).
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_pwm`, input, 1: asynchronous PWM input.
- `o_duty`, output, CNT_W: last valid duty measurement, in high cycles per frame.
- `o_valid`, output, 1: one-cycle pulse, asserted when `o_duty` is updated.
- `o_err`, output, 1: one-cycle pulse, asserted when a malformed frame is detected.

## Operation
- **Input conditioning**
  - `i_pwm` passes through a 2-flop synchronizer to give `s`.
  - `s_d` is `s` registered one more cycle.
  - `rise = s & ~s_d`.
- **Registers:** `state` (SEARCH or MEASURE), `per_cnt`, `hi_cnt`, `lvl_cnt`. All are CNT_W wide except `state`.
- **Static-level detector.** Runs in every state.
  - When `s != s_d`: `lvl_cnt <= 1`.
  - Else, when `lvl_cnt == PERIOD−1`: this is a static report.
    - `o_duty <= s ? PERIOD : 0`.
    - Pulse `o_valid`.
    - `lvl_cnt <= 0`.
    - `state <= SEARCH`.
  - Else: `lvl_cnt <= lvl_cnt+1`.
  - While the level holds, the report repeats every PERIOD cycles.
- **SEARCH state.**
  - On `rise`: go to MEASURE, with `per_cnt <= 1` and `hi_cnt <= 1`.
  - No other action.
- **MEASURE state, on `rise`.**
  - If `per_cnt == PERIOD`: `o_duty <= hi_cnt` and pulse `o_valid`.
  - Otherwise the period was short: pulse `o_err` and leave `o_duty` unchanged.
  - In both cases restart the frame with `per_cnt <= 1` and `hi_cnt <= 1`, staying in MEASURE.
- **MEASURE state, no `rise` and `per_cnt == PERIOD`.** This is an overrun.
  - Pulse `o_err`.
  - Go to SEARCH.
- **MEASURE state, otherwise.**
  - `per_cnt <= per_cnt+1`.
  - `hi_cnt <= hi_cnt + s`.
- **Priority:** a static report overrides an overrun on the same edge, giving `o_valid`=1 and `o_err`=0. `rise` and a static report cannot coincide.
- **Counter bounds:** `per_cnt` never exceeds PERIOD; `hi_cnt ≤ per_cnt`. No wrap-around is possible within the legal parameter range.
- **Transitions into a static level**
  - Into 100%: the high run starts at a rise. The static report fires on the PERIOD-th sample, before the overrun check, so no `o_err`.
  - Into 0%: exactly one overrun `o_err`, then the static report with duty 0.
- **Reset behaviour**
  - Reset, including assertion mid-frame, clears all registers, including both synchronizer flops and `s_d`.
  - `state` = SEARCH, `o_duty` = 0, `o_valid` = 0, `o_err` = 0.
  - After reset, the first `rise` only arms MEASURE. The first frame report comes on the second `rise`.

## Timing
- Reset values: `o_duty` = 0, `o_valid` = 0, `o_err` = 0.
- All outputs are registered.
- Input latency:
  - An `i_pwm` rising edge is captured at clock edge n.
  - `s` is high after edge n+1.
  - `o_valid` or `o_err` is high for the cycle after edge n+2.
- Duty measured = number of high samples of `s` in the frame that starts at one `rise` and ends just before the next.
- Static report with `i_pwm` held low from reset: first `o_valid` (duty 0) after the PERIOD-th clock edge following reset release, then every PERIOD edges.
- `o_valid` and `o_err` are never both high. Each is high for exactly one cycle per event.

## Test plan
- **Static low from reset.** Release reset with `i_pwm`=0 → `o_valid` after edge 10 with `o_duty`=0. Repeats every 10 cycles. `o_err` never asserts.
- **Steady 50% duty.** Apply a 10-cycle PWM at duty 5 → no report at the first rise. `o_valid` with `o_duty`=5 at the second rise +2 cycles, then every 10 cycles. No `o_err`.
- **Duty sweep.** Sweep duty 1..9, two frames each → `o_duty` equals the applied duty for every frame after the first of each setting. No `o_err`.
- **Transitions to static levels.**
  - Duty 7, then hold `i_pwm`=1 → `o_duty`=10 on the 10th high sample. No `o_err`.
  - Duty 7, then hold `i_pwm`=0 → one `o_err`, then `o_duty`=0.
- **Wrong period.**
  - Period 8, duty 4 → `o_err` at every rise after the first. `o_duty` holds its prior value. No `o_valid`.
  - Period 12 → one `o_err` per frame from overrun.
- **Reset mid-frame.** Run duty 6, then pulse `i_rst_n` low mid-frame → outputs 0 immediately. The first post-reset `o_valid` (`o_duty`=6) comes only at the second rise after release.

Source files
------------

// File: rtl/pwm_decoder.sv
// ---------------------------------------------------------------------------
// pwm_decoder
//
// Receive-side decoder for a fixed-period PWM stream. The asynchronous input
// is synchronised, every frame (rising edge to rising edge) is timed, and the
// number of high samples in a correctly sized frame is reported as the duty.
// Constant levels that never produce edges are reported as 0 or PERIOD every
// PERIOD cycles. Frames that are too short or too long raise an error pulse.
//
// Parameters
//   PERIOD : expected frame length in clock cycles (2 .. 2^CNT_W-1)
//   CNT_W  : width of the internal counters and of o_duty
//
// Ports
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_pwm   : asynchronous PWM input
//   o_duty  : last valid duty measurement (high cycles per frame)
//   o_valid : one-cycle pulse when o_duty is updated
//   o_err   : one-cycle pulse when a malformed frame is detected
// ---------------------------------------------------------------------------
module pwm_decoder #(
    parameter int PERIOD = 10,
    parameter int CNT_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pwm,
    output logic [CNT_W-1:0] o_duty,
    output logic             o_valid,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Input conditioning
    logic sync1_r;
    logic s_r;
    logic s_d_r;
    logic rise_s;

    // Frame measurement state
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] per_cnt_r;
    logic [CNT_W-1:0] per_cnt_s;
    logic [CNT_W-1:0] hi_cnt_r;
    logic [CNT_W-1:0] hi_cnt_s;
    logic [CNT_W-1:0] lvl_cnt_r;
    logic [CNT_W-1:0] lvl_cnt_s;
    logic             static_s;

    // Registered outputs
    logic [CNT_W-1:0] duty_r;
    logic [CNT_W-1:0] duty_s;
    logic             valid_r;
    logic             valid_s;
    logic             err_r;
    logic             err_s;

    assign rise_s  = s_r & ~s_d_r;
    assign o_duty  = duty_r;
    assign o_valid = valid_r;
    assign o_err   = err_r;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r <= 1'b0;
            s_r     <= 1'b0;
            s_d_r   <= 1'b0;
        end else begin
            sync1_r <= i_pwm;
            s_r     <= sync1_r;
            s_d_r   <= s_r;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_s   = state_r;
        per_cnt_s = per_cnt_r;
        hi_cnt_s  = hi_cnt_r;
        lvl_cnt_s = lvl_cnt_r;
        duty_s    = duty_r;
        valid_s   = 1'b0;
        err_s     = 1'b0;
        static_s  = 1'b0;

        // Static-level detector: counts cycles since the last level change,
        // independent of the frame FSM.
        if (s_r != s_d_r) begin
            lvl_cnt_s = ONE_C;
        end else if (lvl_cnt_r == LAST_C) begin
            static_s  = 1'b1;
            lvl_cnt_s = ZERO_C;
        end else begin
            lvl_cnt_s = lvl_cnt_r + ONE_C;
        end

        case (state_r)
            SEARCH: begin
                if (rise_s) begin
                    state_s   = MEASURE;
                    per_cnt_s = ONE_C;
                    hi_cnt_s  = ONE_C;
                end else begin
                    state_s = SEARCH;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    if (per_cnt_r == PERIOD_C) begin
                        duty_s  = hi_cnt_r;
                        valid_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                    per_cnt_s = ONE_C;
                    hi_cnt_s  = ONE_C;
                end else if (per_cnt_r == PERIOD_C) begin
                    // Frame ran past its expected end without a new rise
                    err_s   = 1'b1;
                    state_s = SEARCH;
                end else begin
                    per_cnt_s = per_cnt_r + ONE_C;
                    hi_cnt_s  = hi_cnt_r + {{(CNT_W-1){1'b0}}, s_r};
                end
            end
            default: begin
                state_s = SEARCH;
            end
        endcase

        // A static report wins over an overrun on the same cycle; a rise
        // cannot coincide with it because a rise resets the level counter.
        if (static_s) begin
            duty_s  = s_r ? PERIOD_C : ZERO_C;
            valid_s = 1'b1;
            err_s   = 1'b0;
            state_s = SEARCH;
        end else begin
            duty_s = duty_s;
        end
    end

    // State, counter and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= SEARCH;
            per_cnt_r <= ZERO_C;
            hi_cnt_r  <= ZERO_C;
            lvl_cnt_r <= ZERO_C;
            duty_r    <= ZERO_C;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            per_cnt_r <= per_cnt_s;
            hi_cnt_r  <= hi_cnt_s;
            lvl_cnt_r <= lvl_cnt_s;
            duty_r    <= duty_s;
            valid_r   <= valid_s;
            err_r     <= err_s;
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_decoder
//
// Directed testbench for pwm_decoder (PERIOD=10, CNT_W=4). Stimulus is driven
// one clock per tick; output pulses are logged on the falling edge together
// with the clock-edge number so report timing can be checked against
// hand-computed values relative to reset release.
// ---------------------------------------------------------------------------
module tb_pwm_decoder;

    logic       clk;
    logic       rst_n;
    logic       pwm;
    logic [3:0] duty;
    logic       valid;
    logic       err;

    int n_checks;
    int n_fail;
    int cyc;
    int rel;
    int vcount;
    int ecount;
    int both_cnt;
    int v0;
    int e0;
    int duty_log [0:255];
    int val_cyc  [0:255];
    int err_cyc  [0:255];

    pwm_decoder #(
        .PERIOD (10),
        .CNT_W  (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_pwm   (pwm),
        .o_duty  (duty),
        .o_valid (valid),
        .o_err   (err)
    );

    initial clk = 1'b0;

    // Free-running clock
    always #5 clk = ~clk;

    // Count active clock edges
    always @(posedge clk) cyc <= cyc + 1;

    // Log every output pulse away from the active edge
    always @(negedge clk) begin
        if (valid && vcount < 256) begin
            duty_log[vcount] <= int'(duty);
            val_cyc[vcount]  <= cyc;
        end
        if (valid) vcount <= vcount + 1;
        if (err && ecount < 256) err_cyc[ecount] <= cyc;
        if (err) ecount <= ecount + 1;
        if (valid && err) both_cnt <= both_cnt + 1;
    end

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one input sample, wait for the edge that captures it
    task automatic tick(input logic v);
        pwm = v;
        @(posedge clk);
        #1;
    endtask

    // Let the falling-edge logger catch up with the last edge
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic run_pwm(input int period, input int d, input int frames);
        for (int f = 0; f < frames; f++) begin
            for (int c = 0; c < period; c++) begin
                tick((c < d) ? 1'b1 : 1'b0);
            end
        end
    endtask

    // Hold reset for a few edges, release on a falling edge; next edge is rel+1
    task automatic do_reset();
        rst_n = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        v0    = vcount;
        e0    = ecount;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        vcount   = 0;
        ecount   = 0;
        both_cnt = 0;
        rel      = 0;
        rst_n    = 1'b0;
        pwm      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_duty", 32'(duty), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // Static low from reset: reports at edges 10 and 20
        do_reset();
        repeat (9) tick(1'b0);
        check_eq("s0_no_early", 32'(valid), 32'd0);
        tick(1'b0);
        check_eq("s0_valid10", 32'(valid), 32'd1);
        check_eq("s0_duty", 32'(duty), 32'd0);
        tick(1'b0);
        check_eq("s0_pulse1", 32'(valid), 32'd0);
        repeat (9) tick(1'b0);
        settle();
        check_eq("s0_count", 32'(vcount - v0), 32'd2);
        check_eq("s0_first_t", 32'(val_cyc[v0] - rel), 32'd10);
        check_eq("s0_repeat_t", 32'(val_cyc[v0+1] - val_cyc[v0]), 32'd10);
        check_eq("s0_no_err", 32'(ecount - e0), 32'd0);

        // Steady 50%: rises at ticks 1,11,21,31,41 -> reports at 13,23,33,43
        do_reset();
        run_pwm(10, 5, 5);
        settle();
        check_eq("d5_count", 32'(vcount - v0), 32'd4);
        check_eq("d5_first_t", 32'(val_cyc[v0] - rel), 32'd13);
        check_eq("d5_repeat_t", 32'(val_cyc[v0+1] - val_cyc[v0]), 32'd10);
        check_eq("d5_duty0", 32'(duty_log[v0]), 32'd5);
        check_eq("d5_duty3", 32'(duty_log[v0+3]), 32'd5);
        check_eq("d5_no_err", 32'(ecount - e0), 32'd0);

        // Duty sweep 1..9, two frames each: 18 rises -> 17 reports
        do_reset();
        for (int d = 1; d <= 9; d++) run_pwm(10, d, 2);
        settle();
        check_eq("sw_count", 32'(vcount - v0), 32'd17);
        for (int k = 0; k < 17; k++) begin
            check_eq($sformatf("sw_duty%0d", k), 32'(duty_log[v0+k]), 32'(1 + k / 2));
        end
        check_eq("sw_no_err", 32'(ecount - e0), 32'd0);

        // Duty 7 then held high: reports at 13, 23 (duty 7) and 32 (duty 10)
        do_reset();
        run_pwm(10, 7, 2);
        repeat (20) tick(1'b1);
        settle();
        check_eq("hi_count", 32'(vcount - v0), 32'd3);
        check_eq("hi_duty7", 32'(duty_log[v0+1]), 32'd7);
        check_eq("hi_duty10", 32'(duty_log[v0+2]), 32'd10);
        check_eq("hi_static_t", 32'(val_cyc[v0+2] - rel), 32'd32);
        check_eq("hi_no_err", 32'(ecount - e0), 32'd0);

        // Duty 7 then held low: overrun at 23, static zero at 29, 39, 49
        do_reset();
        run_pwm(10, 7, 2);
        repeat (30) tick(1'b0);
        settle();
        check_eq("lo_err_count", 32'(ecount - e0), 32'd1);
        check_eq("lo_err_t", 32'(err_cyc[e0] - rel), 32'd23);
        check_eq("lo_count", 32'(vcount - v0), 32'd4);
        check_eq("lo_duty7", 32'(duty_log[v0]), 32'd7);
        check_eq("lo_duty0", 32'(duty_log[v0+1]), 32'd0);
        check_eq("lo_static_t", 32'(val_cyc[v0+1] - rel), 32'd29);

        // Short period: 3 good frames of duty 5, then period 8 frames
        do_reset();
        run_pwm(10, 5, 3);
        run_pwm(8, 4, 5);
        settle();
        check_eq("p8_valid_count", 32'(vcount - v0), 32'd3);
        check_eq("p8_last_valid_t", 32'(val_cyc[v0+2] - rel), 32'd33);
        check_eq("p8_err_count", 32'(ecount - e0), 32'd4);
        check_eq("p8_err_t", 32'(err_cyc[e0] - rel), 32'd41);
        check_eq("p8_duty_hold", 32'(duty), 32'd5);

        // Long period 12: overrun each frame, each following rise only re-arms
        do_reset();
        run_pwm(12, 6, 4);
        settle();
        check_eq("p12_err_count", 32'(ecount - e0), 32'd3);
        check_eq("p12_err_t", 32'(err_cyc[e0] - rel), 32'd13);
        check_eq("p12_no_valid", 32'(vcount - v0), 32'd0);

        // Reset mid-frame
        do_reset();
        run_pwm(10, 6, 2);
        repeat (4) tick(1'b1);
        check_eq("mr_pre_duty", 32'(duty), 32'd6);
        rst_n = 1'b0;
        #1;
        check_eq("mr_duty", 32'(duty), 32'd0);
        check_eq("mr_valid", 32'(valid), 32'd0);
        check_eq("mr_err", 32'(err), 32'd0);
        do_reset();
        run_pwm(10, 6, 3);
        settle();
        check_eq("mr_count", 32'(vcount - v0), 32'd2);
        check_eq("mr_first_t", 32'(val_cyc[v0] - rel), 32'd13);
        check_eq("mr_duty6", 32'(duty_log[v0]), 32'd6);
        check_eq("mr_no_err", 32'(ecount - e0), 32'd0);

        check_eq("never_both", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
